// File: rtl/seg_scan_driver_if.sv
// Write port of the digit register file: strobe, hex value and digit index.
// The writer uses the master modport and the scan driver uses the slave modport.
interface seg_scan_driver_if #(
    parameter int AW = 2
) ();
    logic          Load;
    logic [3:0]    Din;
    logic [AW-1:0] Addr;

    modport master (output Load, Din, Addr);
    modport slave  (input  Load, Din, Addr);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: N hex digit registers shown one slot at a time
// on an active-low segment bus, with a dark gap at the start of every slot.
module seg_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int AW           = 2,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_driver_if.slave    wr,
    output logic [6:0]          Seg,
    output logic [N_DIGITS-1:0] An,
    output logic                Frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(N_DIGITS);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [SW-1:0]       slot, slot_n;
    logic [6:0]          seg_n;
    logic [N_DIGITS-1:0] an_n;
    logic                frame_n;
    logic [3:0]          digits [N_DIGITS];

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Out-of-range addresses match no register and are silently dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_DIGITS; i++) digits[i] <= 4'h0;
        end else if (wr.Load) begin
            for (int i = 0; i < N_DIGITS; i++)
                if (wr.Addr == AW'(i)) digits[i] <= wr.Din;
        end
    end

    // The digit is sampled only on entry to DRIVE, so later writes cannot tear the display
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        slot_n  = slot;
        seg_n   = Seg;
        an_n    = An;
        frame_n = 1'b0;
        case (state)
            BLANK: begin
                seg_n = 7'h7F;
                an_n  = '1;
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state_n = DRIVE;
                    seg_n   = decode(digits[slot]);
                    an_n    = ~(N_DIGITS'(1) << slot);
                end
            end
            DRIVE: begin
                if (cnt == CW'(REFRESH_DIV - 1)) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    slot_n  = (slot == SW'(N_DIGITS - 1)) ? '0 : slot + 1'b1;
                    seg_n   = 7'h7F;
                    an_n    = '1;
                    frame_n = (slot == SW'(N_DIGITS - 1));
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= BLANK;
            cnt        <= '0;
            slot       <= '0;
            Seg        <= 7'h7F;
            An         <= '1;
            Frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            slot       <= slot_n;
            Seg        <= seg_n;
            An         <= an_n;
            Frame_done <= frame_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a fixed vector table, then a cycle-count
// reference model feeding a scoreboard queue, plus directed corner-case sequences.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int AW = 3;
    localparam int FR = N * R;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] Seg;
    logic [3:0] An;
    logic       Frame_done;

    seg_scan_driver_if #(.AW(AW)) bus ();

    seg_scan_driver #(
        .N_DIGITS(N), .AW(AW), .REFRESH_DIV(R), .BLANK_CYCLES(B)
    ) dut (
        .clk(clk), .reset(reset), .wr(bus),
        .Seg(Seg), .An(An), .Frame_done(Frame_done)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       load;
        logic [2:0] addr;
        logic [3:0] din;
        logic [6:0] seg;
        logic [3:0] an;
        logic       frame;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[13];
    logic [6:0] decTab[16];
    logic [3:0] mdig[N];
    logic [6:0] mShown;
    int         k;
    int         checks, errors;
    int         cycle, lastFrame, frameCount;
    bit         spacingOn;
    logic [6:0] slotSeg[N];
    logic [3:0] slotAn[N];

    // Model works from the absolute cycle count since reset rather than a state machine
    function exp_t modelStep(input logic rst, input logic load,
                             input logic [2:0] addr, input logic [3:0] din);
        exp_t       e;
        int         p, s;
        logic [3:0] oh;
        if (!rst) begin
            for (int i = 0; i < N; i++) mdig[i] = 4'h0;
            k = 0;
            e = {7'h7F, 4'hF, 1'b0};
        end else begin
            k++;
            p = k % R;
            s = (k / R) % N;
            if (p == B) mShown = decTab[mdig[s]];
            if (load && addr < N) mdig[addr] = din;
            if (p < B) begin
                e.seg = 7'h7F;
                e.an  = 4'hF;
            end else begin
                oh    = 4'b0001 << s;
                e.seg = mShown;
                e.an  = ~oh;
            end
            e.frame = (k % FR == 0);
        end
        return e;
    endfunction

    task check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: queue empty at cycle %0d", cycle);
        end else begin
            e = sbq.pop_front();
            check("seg", {25'd0, Seg}, {25'd0, e.seg});
            check("an", {28'd0, An}, {28'd0, e.an});
            check("frame", {31'd0, Frame_done}, {31'd0, e.frame});
        end
        check("an_onehot", {31'd0, ($countones(~An) <= 1)}, 32'd1);
        if (Frame_done) begin
            frameCount++;
            if (spacingOn && lastFrame >= 0) check("frame_spacing", cycle - lastFrame, FR);
            lastFrame = cycle;
        end
    endtask

    task applyStimulus(input logic rst, input logic load, input logic [2:0] addr,
                       input logic [3:0] din, input bit useTab, input exp_t tabExp);
        exp_t m;
        reset    = rst;
        bus.Load = load;
        bus.Addr = addr;
        bus.Din  = din;
        m = modelStep(rst, load, addr, din);
        sbq.push_back(useTab ? tabExp : m);
        if (!rst) lastFrame = -1;
        @(posedge clk);
        #1;
        cycle++;
        checkOutput();
    endtask

    task idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 1'b0, '0);
    endtask

    initial begin
        checks = 0; errors = 0; cycle = 0; lastFrame = -1; frameCount = 0;
        spacingOn = 1'b0; k = 0; mShown = 7'h7F;
        reset = 1'b0; bus.Load = 1'b0; bus.Addr = '0; bus.Din = '0;

        decTab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        slotSeg = '{7'h0E, 7'h06, 7'h79, 7'h10};
        slotAn  = '{4'hE, 4'hD, 4'hB, 4'h7};

        vecs[0]  = '{1'b0, 1'b0, 3'd0, 4'h0, 7'h7F, 4'hF, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 4'h0, 7'h7F, 4'hF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd3, 4'h7, 7'h7F, 4'hF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd0, 4'h0, 7'h7F, 4'hF, 1'b0};
        for (int i = 4; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 3'd0, 4'h0, 7'h40, 4'hE, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 4'h0, 7'h7F, 4'hF, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'd0, 4'h0, 7'h7F, 4'hF, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'd0, 4'h0, 7'h40, 4'hD, 1'b0};

        for (int i = 0; i < 13; i++)
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].addr, vecs[i].din, 1'b1,
                          {vecs[i].seg, vecs[i].an, vecs[i].frame});

        // Load F,E,1,9 and watch a full frame from its first cycle
        applyStimulus(1'b1, 1'b1, 3'd0, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 3'd1, 4'hE, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 3'd2, 4'h1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 3'd3, 4'h9, 1'b0, '0);
        while (k % FR != 0) idle(1);
        idle(FR);
        for (int s = 0; s < N; s++) begin
            idle(4);
            check("t2_slot_seg", {25'd0, Seg}, {25'd0, slotSeg[s]});
            check("t2_slot_an", {28'd0, An}, {28'd0, slotAn[s]});
            idle(4);
        end

        // Mid-DRIVE write to the shown digit must not change the lit pattern
        idle(3);
        applyStimulus(1'b1, 1'b1, 3'd0, 4'h8, 1'b0, '0);
        check("t3_no_tear", {25'd0, Seg}, {25'd0, 7'h0E});
        while (k % FR != 0) idle(1);
        idle(3);
        check("t3_new_digit", {25'd0, Seg}, {25'd0, 7'h00});
        check("t3_new_an", {28'd0, An}, {28'd0, 4'hE});

        // Reset wins over a simultaneous write; out-of-range address ignored
        applyStimulus(1'b0, 1'b1, 3'd3, 4'h7, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 3'd5, 4'h8, 1'b0, '0);
        idle(27);
        check("t4_slot3_cleared", {25'd0, Seg}, {25'd0, 7'h40});
        check("t4_slot3_an", {28'd0, An}, {28'd0, 4'h7});
        while (k % FR != 0) idle(1);
        idle(3);
        check("t4_slot0_cleared", {25'd0, Seg}, {25'd0, 7'h40});

        // One-edge reset in the middle of slot 2 DRIVE
        idle(17);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, '0);
        check("t5_dark_an", {28'd0, An}, {28'd0, 4'hF});
        check("t5_dark_seg", {25'd0, Seg}, {25'd0, 7'h7F});
        idle(2);
        check("t5_restart_an", {28'd0, An}, {28'd0, 4'hE});

        spacingOn  = 1'b1;
        frameCount = 0;
        repeat (100)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)), 1'b0, '0);
        check("t6_frame_count", frameCount, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Multiplexed display stage downstream of the single-digit seven_segment loader. It holds N_DIGITS hex digit registers, written through the same Load/Din interface plus an address. It time-multiplexes the digits onto one shared active-low segment bus with active-low digit anodes. Each digit slot starts with a blanking gap to suppress ghosting. A one-cycle frame pulse marks the end of every full scan.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
AW, 2, address width, at least clog2(N_DIGITS)
REFRESH_DIV, 1000, clock cycles per digit slot, blank gap included
BLANK_CYCLES, 2, cycles per slot with all anodes off; constraint 1 <= BLANK_CYCLES < REFRESH_DIV

Ports:
clk  input  1  system clock, all logic on the rising edge
reset  input  1  synchronous active-low reset (0 at a rising clk edge resets)
Load  input  1  write strobe for the digit register file
Din  input  4  hex digit value to write
Addr  input  AW  digit index to write
Seg  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit)
An  output  N_DIGITS  digit anodes, active-low, at most one low at a time
Frame_done  output  1  one-cycle pulse at the end of the last slot

Behaviour:
- Reset (reset==0 at posedge):
  - digit regs = 4'h0; slot = 0; cycle counter = 0; state = BLANK.
  - Seg = 7'h7F; An = all 1s; Frame_done = 0.
  - reset overrides Load on the same edge.
  - Reset mid-slot aborts the slot immediately; outputs are dark from the next edge.
- Write: Load==1 at posedge with reset==1 -> digit[Addr] <= Din.
  - Addr >= N_DIGITS is ignored, with no side effects.
  - Writes are accepted every cycle; there is no busy state.
- FSM, two states, all outputs registered:
  - BLANK: An all 1s, Seg 7'h7F. Counter runs 0..BLANK_CYCLES-1.
  - BLANK -> DRIVE on the edge where counter==BLANK_CYCLES-1. On that edge: An[slot] <= 0; Seg <= decode(digit[slot]), using the register value from before the edge.
  - DRIVE: Seg and An are frozen for the whole DRIVE period. A write to the displayed digit during DRIVE, or on the BLANK->DRIVE edge, is not shown until that slot's next visit (no tearing).
  - DRIVE -> BLANK on the edge where counter==REFRESH_DIV-1. On that edge: counter <= 0; slot <= (slot==N_DIGITS-1) ? 0 : slot+1; An all 1s; Seg 7'h7F.
- Frame_done: high for exactly the one cycle after the DRIVE->BLANK edge of slot N_DIGITS-1. Period = N_DIGITS*REFRESH_DIV cycles.
- Slot timing: REFRESH_DIV cycles per slot total, of which BLANK_CYCLES dark and REFRESH_DIV-BLANK_CYCLES lit.
- Decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Invariant: An never has more than one 0 bit, in any cycle.

Test Plan:
(Bench uses N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, 20 ns clock.)
1. Hold reset=0 for 3 edges -> Seg=7F, An=F, Frame_done=0. Release; first two cycles dark, then An=E, Seg=40 (digit 0) for 6 cycles.
2. Write Din=F,E,1,9 to Addr 0..3 -> over the next frame An sequence E,D,B,7 with Seg 0E,06,79,10; 2 dark cycles between each slot; Frame_done pulses once every 32 cycles.
3. Write Addr=0, Din=4'h8 while An=E is in DRIVE -> Seg stays at the old value until the slot ends; on the next frame slot 0 shows Seg=00.
4. Load=1 with Addr=3 and Load=1 simultaneously with reset=0 -> after release, all digits read 0; the reset write is dropped.
5. Assert reset=0 for one edge mid-DRIVE of slot 2 -> next cycle An=F and Seg=7F; the scan restarts at slot 0 after 2 dark cycles; no partial Frame_done pulse.
6. Run 3 full frames with random writes -> checker confirms An is one-hot-low or all-1 every cycle, and the Frame_done spacing is exactly 32 cycles.
